// File: rtl/freq_checker_pkg.sv
// Shared types and constants for the frequency checker and its interval timer.
// The interval period follows the upstream freq_counter's 10 Hz update rate.
`ifndef CLK_FREQ
`define CLK_FREQ 100
`endif

package freq_checker_pkg;

  localparam int unsigned FREQ_W          = 24;
  localparam int unsigned FAIL_W          = 8;
  localparam int unsigned INTERVAL_CYCLES = `CLK_FREQ / 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/freq_checker_if.sv
// Control/result bundle between a requester and freq_checker.
// Handshake: start is a one-cycle request, accepted only while busy is low;
// done is a level that stays high with pass/min/max/fail_count valid until the
// next accepted start or reset.
interface freq_checker_if;

  logic                                 start;
  logic [freq_checker_pkg::FREQ_W-1:0]  freq;
  logic [freq_checker_pkg::FREQ_W-1:0]  lo_limit;
  logic [freq_checker_pkg::FREQ_W-1:0]  hi_limit;
  logic                                 busy;
  logic                                 done;
  logic                                 pass;
  logic [freq_checker_pkg::FREQ_W-1:0]  min_freq;
  logic [freq_checker_pkg::FREQ_W-1:0]  max_freq;
  logic [freq_checker_pkg::FAIL_W-1:0]  fail_count;
  freq_checker_pkg::state_t             dbg_state;

  modport master (
    output start, freq, lo_limit, hi_limit,
    input  busy, done, pass, min_freq, max_freq, fail_count, dbg_state
  );

  modport slave (
    input  start, freq, lo_limit, hi_limit,
    output busy, done, pass, min_freq, max_freq, fail_count, dbg_state
  );

endinterface

// File: rtl/freq_checker_interval_timer.sv
// Free-running interval tick: one-cycle pulse every PERIOD cycles, the first
// one PERIOD cycles after reset is released.
module interval_timer #(
  parameter int unsigned PERIOD = 10
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CNT_W-1:0] r_count;
  logic             w_tick;

  assign w_tick = (r_count == CNT_W'(PERIOD - 1));
  assign o_tick = w_tick;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (w_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/freq_checker.sv
// Checks that a measured frequency stays within [lo,hi] over a run of
// intervals after a settling period, reporting min/max and a fail count.
module freq_checker
  import freq_checker_pkg::*;
#(
  parameter int unsigned SETTLE_INTERVALS = 3,
  parameter int unsigned CHECK_INTERVALS  = 8
) (
  input  logic sys_clock,
  input  logic reset,
  freq_checker_if.slave bus
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_INTERVALS - 1);
  localparam logic [7:0] CHECK_LAST  = 8'(CHECK_INTERVALS - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [FREQ_W-1:0]   r_lo;
  logic [FREQ_W-1:0]   r_hi;
  logic [FREQ_W-1:0]   r_min;
  logic [FREQ_W-1:0]   r_max;
  logic [FAIL_W-1:0]   r_fail;
  logic [7:0]          r_settle_cnt;
  logic [7:0]          r_sample_cnt;
  logic                w_tick;
  logic                w_accept;
  logic                w_out_of_range;
  logic [FAIL_W-1:0]   w_fail_next;
  logic                w_busy;
  logic                w_done;
  logic                w_pass;

  interval_timer #(.PERIOD(INTERVAL_CYCLES)) u_interval_timer (
    .i_clk  (sys_clock),
    .i_rst  (reset),
    .o_tick (w_tick)
  );

  assign w_accept = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  // An inverted window (lo > hi) makes every sample fail with no special case.
  assign w_out_of_range = (bus.freq < r_lo) || (bus.freq > r_hi);
  assign w_fail_next    = (w_out_of_range && (r_fail != '1)) ? r_fail + 1'b1 : r_fail;

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    w_pass       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        w_busy = 1'b1;
        if (w_tick && (r_settle_cnt == SETTLE_LAST)) w_state_next = ST_CHECK;
      end
      ST_CHECK: begin
        w_busy = 1'b1;
        if (w_tick && (r_sample_cnt == CHECK_LAST)) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        w_done = 1'b1;
        w_pass = (r_fail == '0);
        if (w_accept) w_state_next = ST_SETTLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      r_lo         <= '0;
      r_hi         <= '0;
      r_min        <= '0;
      r_max        <= '0;
      r_fail       <= '0;
      r_settle_cnt <= '0;
      r_sample_cnt <= '0;
    end else if (w_accept) begin
      r_lo         <= bus.lo_limit;
      r_hi         <= bus.hi_limit;
      r_min        <= '1;
      r_max        <= '0;
      r_fail       <= '0;
      r_settle_cnt <= '0;
      r_sample_cnt <= '0;
    end else if (w_tick) begin
      if (r_state == ST_SETTLE) begin
        r_settle_cnt <= r_settle_cnt + 8'd1;
      end
      if (r_state == ST_CHECK) begin
        r_sample_cnt <= r_sample_cnt + 8'd1;
        r_fail       <= w_fail_next;
        if (bus.freq < r_min) r_min <= bus.freq;
        if (bus.freq > r_max) r_max <= bus.freq;
      end
    end
  end

  assign bus.busy       = w_busy;
  assign bus.done       = w_done;
  assign bus.pass       = w_pass;
  assign bus.min_freq   = r_min;
  assign bus.max_freq   = r_max;
  assign bus.fail_count = r_fail;
  assign bus.dbg_state  = r_state;

endmodule
